harness_ctrl: RTL

Synthesizable, parametrised run controller for simulation and emulation harnesses. It holds the device under test in a staggered multi-domain reset, counts run cycles once reset releases, and gates a waveform-dump window by cycle number. It also latches the run outcome from a pass, fail or timeout condition. It sits between the top-level clock/reset source and the tester/DUT, and replaces free-running testbench counters with one block that behaves identically in simulation and on an emulator.

---
 rtl/harness_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/harness_ctrl.sv
// Run controller for simulation/emulation harnesses: staggered DUT reset release,
// run-cycle counter, waveform dump window and sticky pass/fail/timeout outcome.
module harness_ctrl #(
  parameter int unsigned CYCLE_W      = 64,
  parameter int unsigned N_RST        = 3,
  parameter int unsigned RESET_CYCLES = 6,
  parameter int unsigned RST_STAGGER  = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic [N_RST-1:0]   rst_out,
  output logic [CYCLE_W-1:0] cycle,
  input  logic [CYCLE_W-1:0] dump_start,
  input  logic [CYCLE_W-1:0] dump_stop,
  output logic               dump_en,
  input  logic [CYCLE_W-1:0] timeout,
  input  logic               done_in,
  input  logic               fail_in,
  output logic               finished,
  output logic               passed,
  output logic               timed_out
);

  localparam int unsigned SeqT = RESET_CYCLES + (N_RST - 1) * RST_STAGGER;
  localparam int unsigned SeqW = $clog2(SeqT + 1);
  localparam logic [SeqW-1:0] SeqMax = SeqW'(SeqT);

  typedef enum logic [1:0] {
    StHold,
    StRelease,
    StRun,
    StFinished
  } state_e;

  state_e             state_q, state_d;
  logic [SeqW-1:0]    seq_q, seq_d;
  logic [N_RST-1:0]   rst_q, rst_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic               dump_q, dump_d;
  logic               fin_q, fin_d;
  logic               pass_q, pass_d;
  logic               to_q, to_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StHold;
      seq_q   <= '0;
      rst_q   <= {N_RST{1'b1}};
      cycle_q <= '0;
      dump_q  <= 1'b0;
      fin_q   <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      rst_q   <= rst_d;
      cycle_q <= cycle_d;
      dump_q  <= dump_d;
      fin_q   <= fin_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    rst_d   = rst_q;
    cycle_d = cycle_q;
    dump_d  = 1'b0;
    fin_d   = fin_q;
    pass_d  = pass_q;
    to_d    = to_q;

    case (state_q)
      StHold, StRelease: begin
        if (seq_q != SeqMax) begin
          seq_d = seq_q + 1'b1;
        end
        for (int unsigned i = 0; i < N_RST; i++) begin
          if (seq_d == SeqW'(RESET_CYCLES + i * RST_STAGGER)) begin
            rst_d[i] = 1'b0;
          end
        end
        // Last domain releasing wins, so N_RST=1 or zero stagger skips RELEASE.
        if (!rst_d[N_RST-1]) begin
          state_d = StRun;
        end else if (!rst_d[0]) begin
          state_d = StRelease;
        end
      end
      StRun: begin
        if (fail_in) begin
          state_d = StFinished;
          fin_d   = 1'b1;
          pass_d  = 1'b0;
        end else if (done_in) begin
          state_d = StFinished;
          fin_d   = 1'b1;
          pass_d  = 1'b1;
        end else if ((timeout != '0) && (cycle_q >= timeout)) begin
          state_d = StFinished;
          fin_d   = 1'b1;
          to_d    = 1'b1;
        end
      end
      StFinished: begin
        state_d = StFinished;
      end
      default: begin
        state_d = StHold;
      end
    endcase

    // Counting starts the edge after rst_out[0] has fallen; a finishing edge freezes it.
    if ((state_d != StFinished) && !rst_q[0]) begin
      if (cycle_q != '1) begin
        cycle_d = cycle_q + 1'b1;
      end
      dump_d = (cycle_d >= dump_start) && ((dump_stop == '0) || (cycle_d < dump_stop));
    end
  end

  assign rst_out   = rst_q;
  assign cycle     = cycle_q;
  assign dump_en   = dump_q;
  assign finished  = fin_q;
  assign passed    = pass_q;
  assign timed_out = to_q;

endmodule
